// File: rtl/mem_access_unit.sv
// mem_access_unit: initiator-side load/store unit for a byte-addressed,
// little-endian data memory with a combinational-read / synchronous-write
// word port. Sub-word stores use read-modify-write; sub-word loads are
// lane-extracted and sign/zero-extended.
// Optional build macro: MAU_MISALIGN_CHECK_EN (reject misaligned half/word).
module mem_access_unit #(
    parameter int unsigned MEM_BYTES = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_writeData,
    output logic        mem_writeMem,
    input  logic [31:0] mem_data
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [31:0] wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;

    logic [31:0] req_word_addr_s;
    logic        range_err_s;
    logic        misalign_err_s;

    // Replace one byte/half lane of a memory word with store data (size 2/3 = whole word).
    function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lo);
        logic [31:0] r;
        r = word;
        case (size)
            2'd0:    r[{lo, 3'b000} +: 8] = wdata[7:0];
            2'd1:    r[{lo[1], 4'b0000} +: 16] = wdata[15:0];
            default: r = wdata;
        endcase
        return r;
    endfunction

    // Select the addressed lane of a memory word and extend it to 32 bits.
    function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic        sign,
                                                 input logic [1:0]  lo);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lo, 3'b000} +: 8];
        h = word[{lo[1], 4'b0000} +: 16];
        case (size)
            2'd0:    r = sign ? {{24{b[7]}}, b} : {24'd0, b};
            2'd1:    r = sign ? {{16{h[15]}}, h} : {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    assign req_word_addr_s = {req_addr[31:2], 2'b00};
    assign range_err_s     = (req_word_addr_s >= MEM_LIMIT);

`ifdef MAU_MISALIGN_CHECK_EN
    assign misalign_err_s = ((req_size == 2'd1) && req_addr[0]) ||
                            (req_size[1] && (req_addr[1:0] != 2'd0));
`else
    assign misalign_err_s = 1'b0;
`endif

    // Next-state and next-output computation; outputs are registered from these values.
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        sign_d       = sign_q;
        addr_lo_d    = addr_lo_q;
        wdata_d      = wdata_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d     = req_write;
                    size_d      = req_size;
                    sign_d      = req_sign;
                    addr_lo_d   = req_addr[1:0];
                    wdata_d     = req_wdata;
                    req_ready_d = 1'b0;
                    if (range_err_s || misalign_err_s) begin
                        // Rejected: skip memory entirely and report.
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'd0;
                    end else if (req_write && req_size[1]) begin
                        state_d     = WRITE;
                        mem_addr_d  = req_word_addr_s;
                        mem_wdata_d = req_wdata;
                        mem_we_d    = 1'b1;
                    end else begin
                        state_d    = READ;
                        mem_addr_d = req_word_addr_s;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            READ: begin
                // The read word is captured here: merged into the write word
                // for an RMW store, or lane-extracted into the load result.
                if (write_q) begin
                    state_d     = WRITE;
                    mem_wdata_d = merge_lane(mem_data, wdata_q, size_q, addr_lo_q);
                    mem_we_d    = 1'b1;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = extract_lane(mem_data, size_q, sign_q, addr_lo_q);
                end
            end
            WRITE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = 32'd0;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d      = IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    // State, latched request and registered outputs; async reset aborts any access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            size_q       <= 2'd0;
            sign_q       <= 1'b0;
            addr_lo_q    <= 2'd0;
            wdata_q      <= 32'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            size_q       <= size_d;
            sign_q       <= sign_d;
            addr_lo_q    <= addr_lo_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;
    assign mem_addr      = mem_addr_q;
    assign mem_writeData = mem_wdata_q;
    assign mem_writeMem  = mem_we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a behavioural
// 512-byte memory (combinational read, synchronous write).
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_writeData;
    logic        mem_writeMem;
    logic [31:0] mem_data;

    logic [31:0] mem [0:127] = '{default: 32'h0};
    int          wr_cnt = 0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          wr_base = 0;

    mem_access_unit #(.MEM_BYTES(512)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
        .mem_writeData(mem_writeData), .mem_writeMem(mem_writeMem),
        .mem_data(mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_data = mem[mem_addr[8:2]];

    // Memory model: synchronous write, also counts write strobes seen at edges.
    always @(posedge clk) begin
        if (mem_writeMem) begin
            mem[mem_addr[8:2]] <= mem_writeData;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // Present a request for the acceptance edge; return at the negedge of cycle 1.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        wr_base   = wr_cnt;
        req_write = w;
        req_size  = sz;
        req_sign  = sg;
        req_addr  = a;
        req_wdata = wd;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_resp(input string tag, input int lat);
        while (!resp_valid && cyc < 20) step();
        check(tag, 32'(cyc), 32'(lat));
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_valid_drop", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
    endtask

    task automatic load(input string tag, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] exp);
        issue(1'b0, sz, sg, a, 32'd0);
        wait_resp({tag, "_lat"}, 2);
        check(tag, resp_rdata, exp);
        check({tag, "_err"}, {31'd0, resp_err}, 32'd0);
        finish_resp();
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_sign = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_writeData, 32'd0);
        check("rst_mem_we", {31'd0, mem_writeMem}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Word store 0xDEADBEEF @0x10
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        check("wst_we_c1", {31'd0, mem_writeMem}, 32'd1);
        check("wst_addr_c1", mem_addr, 32'h10);
        check("wst_wdata_c1", mem_writeData, 32'hDEADBEEF);
        wait_resp("wst_lat", 2);
        check("wst_we_c2", {31'd0, mem_writeMem}, 32'd0);
        check("wst_rdata", resp_rdata, 32'd0);
        finish_resp();
        check("wst_wr_cnt", 32'(wr_cnt - wr_base), 32'd1);
        check("wst_mem", mem[4], 32'hDEADBEEF);

        // Word load @0x10
        load("wld", 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        check("wld_no_write", 32'(wr_cnt - wr_base), 32'd0);

        // Byte store 0x55 @0x12: READ then WRITE
        issue(1'b1, 2'd0, 1'b0, 32'h12, 32'h12345655);
        check("bst_we_c1", {31'd0, mem_writeMem}, 32'd0);
        check("bst_addr_c1", mem_addr, 32'h10);
        step();
        check("bst_we_c2", {31'd0, mem_writeMem}, 32'd1);
        check("bst_wdata_c2", mem_writeData, 32'hDE55BEEF);
        wait_resp("bst_lat", 3);
        finish_resp();
        check("bst_wr_cnt", 32'(wr_cnt - wr_base), 32'd1);
        check("bst_mem", mem[4], 32'hDE55BEEF);

        // Sub-word loads
        load("sb_13", 2'd0, 1'b1, 32'h13, 32'hFFFFFFDE);
        load("ub_12", 2'd0, 1'b0, 32'h12, 32'h00000055);
        load("uh_10", 2'd1, 1'b0, 32'h10, 32'h0000BEEF);
        load("sh_12", 2'd1, 1'b1, 32'h12, 32'hFFFFDE55);
        load("sh_10", 2'd1, 1'b1, 32'h10, 32'hFFFFBEEF);

        // Misaligned halfword store @0x11
        issue(1'b1, 2'd1, 1'b0, 32'h11, 32'h00001234);
`ifdef MAU_MISALIGN_CHECK_EN
        wait_resp("mis_lat", 1);
        check("mis_err", {31'd0, resp_err}, 32'd1);
        finish_resp();
        check("mis_no_write", 32'(wr_cnt - wr_base), 32'd0);
        check("mis_mem", mem[4], 32'hDE55BEEF);
`else
        wait_resp("mis_lat", 3);
        check("mis_err", {31'd0, resp_err}, 32'd0);
        finish_resp();
        check("mis_wr_cnt", 32'(wr_cnt - wr_base), 32'd1);
        check("mis_mem", mem[4], 32'hDE551234);
`endif

        // Out-of-range word load @0x200 with 5 cycles of backpressure
        issue(1'b0, 2'd2, 1'b0, 32'h200, 32'd0);
        wait_resp("oor_lat", 1);
        req_write = 1'b1; req_size = 2'd2; req_addr = 32'h20;
        req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("oor_valid_hold", {31'd0, resp_valid}, 32'd1);
            check("oor_err_hold", {31'd0, resp_err}, 32'd1);
            check("oor_rdata_hold", resp_rdata, 32'd0);
            check("oor_ready_low", {31'd0, req_ready}, 32'd0);
            step();
        end
        req_valid = 1'b0;
        finish_resp();
        check("oor_no_write", 32'(wr_cnt - wr_base), 32'd0);
        check("oor_ignored_req", mem[8], 32'd0);

        // Reset during WRITE of a byte store @0x14
        issue(1'b1, 2'd0, 1'b0, 32'h14, 32'h000000AA);
        step();
        check("rw_we_before", {31'd0, mem_writeMem}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rw_we_async_drop", {31'd0, mem_writeMem}, 32'd0);
        @(negedge clk);
        check("rw_mem_unchanged", mem[5], 32'd0);
        check("rw_no_write", 32'(wr_cnt - wr_base), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rw_req_ready", {31'd0, req_ready}, 32'd1);
        check("rw_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("rw_resp_valid_later", {31'd0, resp_valid}, 32'd0);
        check("rw_mem_later", mem[5], 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
